game_countdown_timer: RTL and testbench

//  Consumer of the slow 1 s tick pulse stream: gates the tick generator's enable and

---
 rtl/game_pkg.sv | 21 ++
 rtl/bcd_down_digit.sv | 39 +++
 rtl/game_countdown_timer.sv | 123 ++++++++++++
 tb/tb_game_countdown_timer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: FSM state encoding, BCD digit width and binary-to-BCD helper.
package game_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [2*BCD_DIGIT_W-1:0] to_bcd2(input int unsigned v);
    logic [BCD_DIGIT_W-1:0] tens;
    logic [BCD_DIGIT_W-1:0] ones;
    tens = BCD_DIGIT_W'(v / 10);
    ones = BCD_DIGIT_W'(v % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One loadable BCD down-counting digit; borrow flags a decrement that wraps 0 -> 9.
module bcd_down_digit
  import game_pkg::*;
#(
  parameter logic [BCD_DIGIT_W-1:0] RST_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dec,
  input  logic                   load,
  input  logic [BCD_DIGIT_W-1:0] load_val,
  output logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] digit_d,
  output logic                   borrow
);

  logic [BCD_DIGIT_W-1:0] digit_q;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_val;
    end else if (dec) begin
      digit_d = (digit_q == '0) ? BCD_DIGIT_W'(9) : digit_q - BCD_DIGIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q <= RST_VAL;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit  = digit_q;
  assign borrow = dec && (digit_q == '0);

endmodule

// File: rtl/game_countdown_timer.sv
// Round timer: counts START_SECONDS down to 00 in BCD on 1 s ticks, with pause/restart
// control, a tick-generator enable, a low-time warning and a one-cycle expiry pulse.
module game_countdown_timer
  import game_pkg::*;
#(
  parameter int unsigned START_SECONDS = 60,
  parameter int unsigned WARN_SECONDS  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       tick,
  output logic       tick_en,
  output logic [7:0] time_bcd,
  output logic       running,
  output logic       low_time,
  output logic       expired
);

  if (START_SECONDS < 1 || START_SECONDS > 99) begin : g_bad_start
    $error("START_SECONDS must be in 1..99");
  end
  if (WARN_SECONDS > START_SECONDS) begin : g_bad_warn
    $error("WARN_SECONDS must be in 0..START_SECONDS");
  end

  localparam logic [7:0] START_BCD = to_bcd2(START_SECONDS);
  localparam logic [7:0] WARN_BCD  = to_bcd2(WARN_SECONDS);

  state_e     state_q, state_d;
  logic       load, dec, expired_d;
  logic       ones_borrow, tens_borrow_unused;
  logic [3:0] ones_q, tens_q, ones_d, tens_d;
  logic [7:0] time_d;
  logic       tick_en_q, running_q, low_time_q, expired_q;

  assign time_bcd = {tens_q, ones_q};
  assign time_d   = {tens_d, ones_d};

  // Inputs are only honoured in the state they apply to; stray ticks outside RUN fall through.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    dec       = 1'b0;
    expired_d = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (start) begin
          load = 1'b1;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end else if (tick && time_bcd != 8'h00) begin
          dec = 1'b1;
          if (time_bcd == 8'h01) begin
            state_d   = ST_DONE;
            expired_d = 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end else if (!pause) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  bcd_down_digit #(.RST_VAL(START_BCD[3:0])) u_ones (
    .clk      (clk),
    .rst      (rst),
    .dec      (dec),
    .load     (load),
    .load_val (START_BCD[3:0]),
    .digit    (ones_q),
    .digit_d  (ones_d),
    .borrow   (ones_borrow)
  );

  bcd_down_digit #(.RST_VAL(START_BCD[7:4])) u_tens (
    .clk      (clk),
    .rst      (rst),
    .dec      (ones_borrow),
    .load     (load),
    .load_val (START_BCD[7:4]),
    .digit    (tens_q),
    .digit_d  (tens_d),
    .borrow   (tens_borrow_unused)
  );

  // Outputs follow the next state so they line up with the time_bcd update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tick_en_q  <= 1'b0;
      running_q  <= 1'b0;
      low_time_q <= 1'b0;
      expired_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_en_q  <= (state_d == ST_RUN);
      running_q  <= (state_d == ST_RUN);
      low_time_q <= ((state_d == ST_RUN) || (state_d == ST_PAUSE)) && (time_d <= WARN_BCD);
      expired_q  <= expired_d;
    end
  end

  assign tick_en  = tick_en_q;
  assign running  = running_q;
  assign low_time = low_time_q;
  assign expired  = expired_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Directed bench for game_countdown_timer: a 3 s instance and a 12 s / warn-10 instance.
module tb_game_countdown_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_start, a_pause, a_tick;
  logic       a_tick_en, a_running, a_low, a_exp;
  logic [7:0] a_time;
  logic       b_start, b_pause, b_tick;
  logic       b_tick_en, b_running, b_low, b_exp;
  logic [7:0] b_time;

  int n_pass  = 0;
  int n_total = 0;

  game_countdown_timer #(.START_SECONDS(3), .WARN_SECONDS(1)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .pause(a_pause), .tick(a_tick),
    .tick_en(a_tick_en), .time_bcd(a_time), .running(a_running),
    .low_time(a_low), .expired(a_exp)
  );

  game_countdown_timer #(.START_SECONDS(12), .WARN_SECONDS(10)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .pause(b_pause), .tick(b_tick),
    .tick_en(b_tick_en), .time_bcd(b_time), .running(b_running),
    .low_time(b_low), .expired(b_exp)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic a_tick_pulse();
    a_tick = 1'b1;
    cyc(1);
    a_tick = 1'b0;
  endtask

  task automatic b_tick_pulse();
    b_tick = 1'b1;
    cyc(1);
    b_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_start = 0; a_pause = 0; a_tick = 0;
    b_start = 0; b_pause = 0; b_tick = 0;
    cyc(3);
    rst = 1'b0;
    n_total++;
    if ({a_time, a_tick_en, a_running, a_low, a_exp} !== {8'h03, 4'b0000})
      $display("FAIL reset_a: got time=%h flags=%b%b%b%b want time=03 flags=0000",
               a_time, a_tick_en, a_running, a_low, a_exp);
    else n_pass++;
    n_total++;
    if ({b_time, b_tick_en, b_running, b_low, b_exp} !== {8'h12, 4'b0000})
      $display("FAIL reset_b: got time=%h flags=%b%b%b%b want time=12 flags=0000",
               b_time, b_tick_en, b_running, b_low, b_exp);
    else n_pass++;
  endtask

  task automatic test_countdown_to_done();
    logic [7:0] exp_t [3] = '{8'h02, 8'h01, 8'h00};
    a_start = 1'b1;
    cyc(1);
    a_start = 1'b0;
    n_total++;
    if ({a_time, a_running, a_tick_en} !== {8'h03, 2'b11})
      $display("FAIL start_a: got time=%h run=%b ten=%b want 03 1 1", a_time, a_running, a_tick_en);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      cyc(4);
      a_tick_pulse();
      n_total++;
      if (a_time !== exp_t[k])
        $display("FAIL count_a[%0d]: got time=%h want %h", k, a_time, exp_t[k]);
      else n_pass++;
      n_total++;
      if (a_exp !== (k == 2))
        $display("FAIL expired_a[%0d]: got %b want %b", k, a_exp, (k == 2));
      else n_pass++;
    end
    n_total++;
    if ({a_running, a_tick_en, a_low} !== 3'b000)
      $display("FAIL done_a: got run=%b ten=%b low=%b want 0 0 0", a_running, a_tick_en, a_low);
    else n_pass++;
    cyc(1);
    n_total++;
    if ({a_exp, a_time} !== {1'b0, 8'h00})
      $display("FAIL expired_drop_a: got exp=%b time=%h want 0 00", a_exp, a_time);
    else n_pass++;
    a_tick_pulse();
    n_total++;
    if ({a_time, a_exp, a_running} !== {8'h00, 2'b00})
      $display("FAIL done_tick_a: got time=%h exp=%b run=%b want 00 0 0", a_time, a_exp, a_running);
    else n_pass++;
  endtask

  task automatic test_borrow();
    logic [7:0] exp_t [5] = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07};
    logic       exp_l [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    b_start = 1'b1;
    cyc(1);
    b_start = 1'b0;
    n_total++;
    if ({b_time, b_low, b_running} !== {8'h12, 2'b01})
      $display("FAIL start_b: got time=%h low=%b run=%b want 12 0 1", b_time, b_low, b_running);
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      cyc(2);
      b_tick_pulse();
      n_total++;
      if ({b_time, b_low} !== {exp_t[k], exp_l[k]})
        $display("FAIL borrow_b[%0d]: got time=%h low=%b want %h %b", k, b_time, b_low, exp_t[k], exp_l[k]);
      else n_pass++;
    end
  endtask

  task automatic test_pause();
    b_pause = 1'b1;
    b_tick  = 1'b1;
    cyc(1);
    b_tick = 1'b0;
    n_total++;
    if ({b_time, b_tick_en, b_running, b_low} !== {8'h07, 3'b001})
      $display("FAIL pause_enter: got time=%h ten=%b run=%b low=%b want 07 0 0 1",
               b_time, b_tick_en, b_running, b_low);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      cyc(5);
      b_tick_pulse();
      n_total++;
      if ({b_time, b_tick_en} !== {8'h07, 1'b0})
        $display("FAIL pause_hold[%0d]: got time=%h ten=%b want 07 0", k, b_time, b_tick_en);
      else n_pass++;
    end
    b_pause = 1'b0;
    cyc(1);
    n_total++;
    if ({b_running, b_tick_en} !== 2'b11)
      $display("FAIL pause_exit: got run=%b ten=%b want 1 1", b_running, b_tick_en);
    else n_pass++;
    b_tick_pulse();
    n_total++;
    if (b_time !== 8'h06)
      $display("FAIL resume_tick: got time=%h want 06", b_time);
    else n_pass++;
  endtask

  task automatic test_restart();
    cyc(2);
    b_tick_pulse();
    n_total++;
    if (b_time !== 8'h05)
      $display("FAIL pre_restart: got time=%h want 05", b_time);
    else n_pass++;
    b_start = 1'b1;
    b_tick  = 1'b1;
    cyc(1);
    b_start = 1'b0;
    b_tick  = 1'b0;
    n_total++;
    if ({b_time, b_running, b_low} !== {8'h12, 2'b10})
      $display("FAIL restart: got time=%h run=%b low=%b want 12 1 0", b_time, b_running, b_low);
    else n_pass++;
  endtask

  task automatic test_low_to_done();
    logic [7:0] exp_t;
    for (int r = 11; r >= 0; r--) begin
      cyc(1);
      b_tick_pulse();
      exp_t = {4'(r / 10), 4'(r % 10)};
      n_total++;
      if ({b_time, b_low, b_exp} !== {exp_t, (r <= 10) && (r > 0), (r == 0)})
        $display("FAIL low_b[%0d]: got time=%h low=%b exp=%b want %h %b %b",
                 r, b_time, b_low, b_exp, exp_t, (r <= 10) && (r > 0), (r == 0));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_round();
    b_start = 1'b1;
    cyc(1);
    b_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      b_tick_pulse();
    end
    n_total++;
    if (b_time !== 8'h04)
      $display("FAIL pre_rst: got time=%h want 04", b_time);
    else n_pass++;
    rst = 1'b1;
    b_tick = 1'b1;
    cyc(1);
    rst = 1'b0;
    b_tick = 1'b0;
    n_total++;
    if ({b_time, b_tick_en, b_running, b_low, b_exp} !== {8'h12, 4'b0000})
      $display("FAIL mid_rst: got time=%h flags=%b%b%b%b want 12 0000",
               b_time, b_tick_en, b_running, b_low, b_exp);
    else n_pass++;
    b_tick_pulse();
    n_total++;
    if ({b_time, b_running} !== {8'h12, 1'b0})
      $display("FAIL idle_tick: got time=%h run=%b want 12 0", b_time, b_running);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_countdown_to_done();
    test_borrow();
    test_pause();
    test_restart();
    test_low_to_done();
    test_reset_mid_round();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
